seq_ctrl: RTL and testbench
===========================

# seq_ctrl

Multi-cycle control sequencer for the RV32I core. Steps each instruction through fetch, decode, execute, memory and writeback. Drives the memory handshake, instruction-register load, ALU operand selects, register-file write and PC update from the instruction decoder's `opcode`/`invalid` outputs. Traps on illegal instructions and on bus timeouts.

## Interface
Parameters:
- `TIMEOUT`, 255 — max cycles `mem_req` may wait for `mem_ack` before a bus trap; legal range 1..65535.

Ports:
- `clk` in 1 — clock; all state changes on rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `opcode` in 5 — decoder `inst[6:2]` of the current IR.
- `invalid` in 1 — decoder illegal-instruction flag.
- `branch_taken` in 1 — ALU compare result; valid in EXEC.
- `mem_ack` in 1 — memory completion; may assert in the same cycle as `mem_req`.
- `mem_req` out 1 — memory access request.
- `mem_we` out 1 — store when 1.
- `mem_addr_sel` out 1 — 0 = PC, 1 = ALU result.
- `ir_load` out 1 — IR captures memory read data.
- `alu_a_sel` out 1 — 0 = rs1, 1 = PC.
- `alu_b_sel` out 1 — 0 = rs2, 1 = imm.
- `rf_we` out 1 — register-file write enable.
- `wb_sel` out 2 — 0 = ALU, 1 = MEM, 2 = PC+4, 3 = IMM.
- `pc_load` out 1 — PC update strobe.
- `pc_sel` out 1 — 0 = PC+4, 1 = ALU target.
- `trap` out 1 — sticky trap flag.
- `trap_cause` out 2 — 0 = none, 1 = illegal, 2 = bus timeout.

## Operation
States: `RST`, `FETCH`, `DECODE`, `EXEC`, `MEM`, `WB`, `TRAP`. All outputs are a combinational function of state and registered fields; no output depends combinationally on `mem_ack` except `ir_load`.

- **RST** — the reset state; all outputs 0. The cycle after `rst` deasserts, the FSM moves to FETCH.
- **FETCH** — `mem_req=1`, `mem_addr_sel=0`. When `mem_ack=1`: `ir_load=1` in that cycle, then go to DECODE.
- **DECODE** — one cycle.
  - `invalid=1` → TRAP with cause 1 (see Configuration).
  - Otherwise latch an op class from `opcode` and go to EXEC.
- **EXEC** — one cycle; ALU selects per op class:
  - LOAD/STORE/OP-IMM/JALR: rs1, imm.
  - OP: rs1, rs2.
  - BRANCH: rs1, rs2.
  - AUIPC/JAL: PC, imm.
  - BRANCH also latches `branch_taken`.
  - Next state: LOAD/STORE → MEM; all others → WB.
- **MEM** — `mem_req=1`, `mem_addr_sel=1`, `mem_we=1` for STORE. On `mem_ack`: LOAD → WB; STORE → WB (no rf write).
- **WB** — one cycle; `pc_load=1`.
  - `pc_sel=1` for JAL/JALR, and for BRANCH when the latched taken bit is 1; else 0.
  - `rf_we=1` for LOAD (wb_sel 1), OP/OP-IMM/AUIPC (0), LUI (3), JAL/JALR (2).
  - Then go to FETCH.
- **TRAP** — absorbing state. `trap=1`, `trap_cause` held, all other outputs 0. Exits only via `rst`.
- **Bus timeout:**
  - A counter clears on entry to FETCH or MEM and increments each cycle with `mem_req=1 && !mem_ack`.
  - Reaching `TIMEOUT` → TRAP with cause 2. `mem_req` deasserts that same edge.
  - `mem_ack` arriving in the cycle the count hits `TIMEOUT` wins: it is a normal completion.
- Stray `mem_ack` outside FETCH/MEM is ignored.

## Timing
- Reset: asserting `rst` forces state RST immediately and asynchronously. All outputs go 0, including mid-transaction: `mem_req` drops at once, and `trap`/`trap_cause` clear.
- Zero-wait memory (ack in the request cycle):
  - ALU/branch/jump instructions: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD/STORE: 5 cycles.
- Each wait cycle adds 1 to FETCH or MEM.
- `opcode`/`invalid` must be stable from DECODE through WB; IR changes only on `ir_load`.

## Configuration
- `SEQ_CTRL_FENCE_EN` defined: opcode 00011 (MISC-MEM/FENCE) with `invalid=1` is treated as a no-op. Sequence: EXEC → WB with `pc_sel=0`, `rf_we=0`.
- Undefined: that opcode traps with cause 1, like any other invalid instruction.

## Structure
- Package `riscv_pkg` holds:
  - opcode constants (LOAD 00000, MISC_MEM 00011, OP_IMM 00100, AUIPC 00101, STORE 01000, OP 01100, LUI 01101, BRANCH 11000, JALR 11001, JAL 11011);
  - the `seq_state_t` enum;
  - the `wb_sel_t` and `trap_cause_t` enums.
- Sub-module `seq_timeout` holds the wait counter (width `$clog2(TIMEOUT+1)`), with `clr`, `inc` and `expired` ports.

## Test plan
- ADD (opcode 01100), ack in the request cycle → FETCH, DECODE, EXEC, WB in 4 cycles; `rf_we=1`, `wb_sel=0`, `pc_sel=0` in WB.
- LOAD with 3-cycle MEM wait → MEM lasts 4 cycles with `mem_addr_sel=1`, `mem_we=0`; WB has `rf_we=1`, `wb_sel=1`.
- Branch:
  - BRANCH with `branch_taken=1` → WB `pc_sel=1`, `rf_we=0`.
  - With `branch_taken=0` → `pc_sel=0`.
- `invalid=1`, opcode 00011:
  - Macro undefined → `trap=1`, `trap_cause=1` from the cycle after DECODE, held 10+ cycles.
  - Macro defined → 4-cycle no-op.
- `TIMEOUT=4`, no ack in FETCH → `trap_cause=2` after 4 request cycles; `mem_req=0` thereafter.
- Timeout boundary and reset:
  - Ack exactly at count 4 → normal completion, no trap.
  - `rst` pulsed mid-MEM → outputs 0 immediately; FETCH resumes the cycle after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode constants, sequencer state, write-back select and trap-cause types
package riscv_pkg;
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;

  typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} seq_state_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_t;
  typedef enum logic [1:0] {TC_NONE, TC_ILLEGAL, TC_BUS} trap_cause_t;
  typedef enum logic [3:0] {C_NOP, C_LOAD, C_STORE, C_OP_IMM, C_OP, C_LUI, C_AUIPC, C_BRANCH, C_JAL, C_JALR} op_class_t;

  // unknown or FENCE opcodes fall into C_NOP: no ALU operands, no rf write, sequential PC
  function automatic op_class_t op_class(input logic [4:0] opc);
    case (opc)
      OPC_LOAD:   return C_LOAD;
      OPC_STORE:  return C_STORE;
      OPC_OP_IMM: return C_OP_IMM;
      OPC_OP:     return C_OP;
      OPC_LUI:    return C_LUI;
      OPC_AUIPC:  return C_AUIPC;
      OPC_BRANCH: return C_BRANCH;
      OPC_JAL:    return C_JAL;
      OPC_JALR:   return C_JALR;
      default:    return C_NOP;
    endcase
  endfunction
endpackage

// File: rtl/seq_timeout.sv
// seq_timeout: bus wait counter that flags the cycle a pending request would reach TIMEOUT
module seq_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired = inc && cnt_q == W'(TIMEOUT - 1);
  // next count: clear outside a memory phase, count unacknowledged request cycles
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
  // wait counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle RV32I control sequencer; define SEQ_CTRL_FENCE_EN to run invalid MISC-MEM as a no-op
module seq_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic       invalid,
  input  logic       branch_taken,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_load,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       pc_load,
  output logic       pc_sel,
  output logic       trap,
  output logic [1:0] trap_cause
);
  seq_state_t  state_q;
  op_class_t   cls_q;
  trap_cause_t cause_q;
  logic        taken_q, illegal, in_mem, inc, expired, exec, wb, jump;
`ifdef SEQ_CTRL_FENCE_EN
  assign illegal = invalid && opcode != OPC_MISC_MEM;
`else
  assign illegal = invalid;
`endif
  assign in_mem = state_q == S_FETCH || state_q == S_MEM;
  assign inc    = in_mem && !mem_ack;

  seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_mem),
    .inc     (inc),
    .expired (expired)
  );

  // sequencer: state, latched op class, branch outcome and sticky trap cause
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_RST;
      cls_q   <= C_NOP;
      taken_q <= 1'b0;
      cause_q <= TC_NONE;
    end else
      case (state_q)
        S_RST:    state_q <= S_FETCH;
        S_FETCH:
          if (mem_ack) state_q <= S_DECODE;
          else if (expired) begin
            state_q <= S_TRAP;
            cause_q <= TC_BUS;
          end
        S_DECODE:
          if (illegal) begin
            state_q <= S_TRAP;
            cause_q <= TC_ILLEGAL;
          end else begin
            state_q <= S_EXEC;
            cls_q   <= op_class(opcode);
          end
        S_EXEC: begin
          taken_q <= branch_taken;
          state_q <= (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
        end
        S_MEM:
          if (mem_ack) state_q <= S_WB;
          else if (expired) begin
            state_q <= S_TRAP;
            cause_q <= TC_BUS;
          end
        S_WB:     state_q <= S_FETCH;
        default:  state_q <= S_TRAP;
      endcase

  // control outputs decoded from state and latched fields; only ir_load sees mem_ack
  always_comb begin
    exec         = state_q == S_EXEC;
    wb           = state_q == S_WB;
    jump         = cls_q == C_JAL || cls_q == C_JALR;
    mem_req      = in_mem;
    mem_we       = state_q == S_MEM && cls_q == C_STORE;
    mem_addr_sel = state_q == S_MEM;
    ir_load      = state_q == S_FETCH && mem_ack;
    alu_a_sel    = exec && (cls_q == C_AUIPC || cls_q == C_JAL);
    alu_b_sel    = exec && (cls_q inside {C_LOAD, C_STORE, C_OP_IMM, C_JALR, C_AUIPC, C_JAL});
    rf_we        = wb && (cls_q inside {C_LOAD, C_OP, C_OP_IMM, C_AUIPC, C_LUI, C_JAL, C_JALR});
    wb_sel       = !wb ? WB_ALU : cls_q == C_LOAD ? WB_MEM : cls_q == C_LUI ? WB_IMM : jump ? WB_PC4 : WB_ALU;
    pc_load      = wb;
    pc_sel       = wb && (jump || (cls_q == C_BRANCH && taken_q));
    trap         = state_q == S_TRAP;
    trap_cause   = cause_q;
  end
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed instruction sequences checked every cycle against a per-phase expectation queue
module tb_seq_ctrl;
  import riscv_pkg::*;
  localparam int TO = 4;
`ifdef SEQ_CTRL_FENCE_EN
  localparam bit FENCE = 1'b1;
`else
  localparam bit FENCE = 1'b0;
`endif

  typedef struct packed {
    logic       req, we, as, irl, a, b, rf;
    logic [1:0] wb;
    logic       pl, ps, tr;
    logic [1:0] tc;
  } ov_t;

  typedef struct {
    int ls;
    bit a_pc, b_imm, rf, jump, br;
    bit [1:0] wb;
  } spec_t;

  logic clk = 1'b0, rst = 1'b0, invalid = 1'b0, branch_taken = 1'b0, mem_ack = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic mem_req, mem_we, mem_addr_sel, ir_load, alu_a_sel, alu_b_sel, rf_we, pc_load, pc_sel, trap;
  logic [1:0] wb_sel, trap_cause;
  ov_t outs, e;
  ov_t q[$];
  int n_tests = 0, n_fail = 0;

  assign outs = {mem_req, mem_we, mem_addr_sel, ir_load, alu_a_sel, alu_b_sel, rf_we, wb_sel, pc_load, pc_sel, trap, trap_cause};

  seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .invalid(invalid), .branch_taken(branch_taken),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_load(ir_load), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .pc_load(pc_load), .pc_sel(pc_sel), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  // what each instruction class asks of the datapath, straight from the opcode table
  function automatic spec_t spec_of(input logic [4:0] op);
    spec_t s = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    case (op)
      OPC_LOAD:   s = '{1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
      OPC_STORE:  s = '{2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      OPC_OP_IMM: s = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
      OPC_OP:     s = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
      OPC_LUI:    s = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3};
      OPC_AUIPC:  s = '{0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
      OPC_BRANCH: s = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
      OPC_JALR:   s = '{0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2};
      OPC_JAL:    s = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2};
      default:    s = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    endcase
    return s;
  endfunction

  task automatic pin(input string n, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // single compare process: one expectation per cycle, sampled mid-cycle
  always @(negedge clk)
    if (q.size() != 0) begin
      e = q.pop_front();
      n_tests++;
      if (outs !== e) begin
        n_fail++;
        $display("FAIL cycle@%0t: got %b expected %b", $time, outs, e);
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic trap_hold(input logic [1:0] c);
    ov_t o;
    repeat (12) begin
      step();
      mem_ack = ~mem_ack;
      o = '0;
      o.tr = 1'b1;
      o.tc = c;
      q.push_back(o);
    end
  endtask

  task automatic reset_seq();
    step();
    rst = 1'b1;
    mem_ack = 1'b0;
    q.push_back('0);
    #1 pin("rst_async_clear", int'({trap, trap_cause, mem_req}), 0);
    step();
    rst = 1'b0;
    q.push_back('0);
  endtask

  // fw/mw: wait cycles before ack in FETCH/MEM; ab: MEM cycle at which rst is pulsed (-1 none)
  task automatic run(input logic [4:0] op, input bit inv, input bit tk, input int fw, input int mw,
                     input int ab, input bit stray);
    spec_t s = spec_of(op);
    ov_t o;
    for (int i = 0; ; i++) begin
      step();
      opcode = op;
      invalid = inv;
      branch_taken = 1'b0;
      mem_ack = (i == fw);
      o = '0;
      o.req = 1'b1;
      o.irl = mem_ack;
      q.push_back(o);
      if (mem_ack) break;
      if (i + 1 == TO) begin
        trap_hold(2'd2);
        return;
      end
    end
    step();
    mem_ack = stray;
    q.push_back('0);
    if (inv && !(FENCE && op == OPC_MISC_MEM)) begin
      trap_hold(2'd1);
      return;
    end
    step();
    branch_taken = tk;
    o = '0;
    o.a = s.a_pc;
    o.b = s.b_imm;
    q.push_back(o);
    if (s.ls != 0)
      for (int j = 0; ; j++) begin
        step();
        branch_taken = 1'b0;
        if (j == ab) begin
          rst = 1'b1;
          mem_ack = 1'b0;
          q.push_back('0);
          #1 pin("rst_mid_mem_req", int'(mem_req), 0);
          step();
          rst = 1'b0;
          q.push_back('0);
          return;
        end
        mem_ack = (j == mw);
        o = '0;
        o.req = 1'b1;
        o.we = (s.ls == 2);
        o.as = 1'b1;
        q.push_back(o);
        if (mem_ack) break;
        if (j + 1 == TO) begin
          trap_hold(2'd2);
          return;
        end
      end
    step();
    mem_ack = stray;
    o = '0;
    o.rf = s.rf;
    o.wb = s.wb;
    o.pl = 1'b1;
    o.ps = s.jump | (s.br & tk);
    q.push_back(o);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 pin("reset_outs", int'(outs), 0);
    step();
    rst = 1'b0;
    q.push_back('0);
    run(OPC_OP, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    #1 pin("add_rf_we", int'(rf_we), 1);
    pin("add_wb_sel", int'(wb_sel), 0);
    pin("add_pc_sel", int'(pc_sel), 0);
    pin("add_pc_load", int'(pc_load), 1);
    run(OPC_LOAD, 1'b0, 1'b0, 0, 3, -1, 1'b0);
    #1 pin("load_rf_we", int'(rf_we), 1);
    pin("load_wb_sel", int'(wb_sel), 1);
    run(OPC_STORE, 1'b0, 1'b0, 1, 0, -1, 1'b1);
    #1 pin("store_rf_we", int'(rf_we), 0);
    run(OPC_BRANCH, 1'b0, 1'b1, 0, 0, -1, 1'b0);
    #1 pin("br_taken_pc_sel", int'(pc_sel), 1);
    pin("br_taken_rf_we", int'(rf_we), 0);
    run(OPC_BRANCH, 1'b0, 1'b0, 0, 0, -1, 1'b1);
    #1 pin("br_not_taken_pc_sel", int'(pc_sel), 0);
    run(OPC_JAL, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    #1 pin("jal_wb_sel", int'(wb_sel), 2);
    pin("jal_pc_sel", int'(pc_sel), 1);
    run(OPC_JALR, 1'b0, 1'b0, 2, 0, -1, 1'b0);
    run(OPC_LUI, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    #1 pin("lui_wb_sel", int'(wb_sel), 3);
    run(OPC_AUIPC, 1'b0, 1'b0, 0, 0, -1, 1'b1);
    run(OPC_OP_IMM, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    run(OPC_OP, 1'b0, 1'b0, 3, 0, -1, 1'b0);
    #1 pin("fetch_boundary_trap", int'(trap), 0);
    pin("fetch_boundary_pc_load", int'(pc_load), 1);
    run(OPC_LOAD, 1'b0, 1'b0, 0, 10, 1, 1'b0);
    run(OPC_OP, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    run(OPC_MISC_MEM, 1'b1, 1'b0, 0, 0, -1, 1'b0);
    #1 pin("fence_trap", int'(trap), int'(!FENCE));
    pin("fence_cause", int'(trap_cause), int'(!FENCE));
    if (trap) reset_seq();
    run(OPC_OP, 1'b1, 1'b0, 0, 0, -1, 1'b0);
    #1 pin("illegal_cause", int'(trap_cause), 1);
    reset_seq();
    run(OPC_OP, 1'b0, 1'b0, 100, 0, -1, 1'b0);
    #1 pin("fetch_timeout_cause", int'(trap_cause), 2);
    pin("fetch_timeout_req", int'(mem_req), 0);
    reset_seq();
    run(OPC_STORE, 1'b0, 1'b0, 0, 100, -1, 1'b0);
    #1 pin("mem_timeout_cause", int'(trap_cause), 2);
    reset_seq();
    run(OPC_OP, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    repeat (3) @(negedge clk);
    pin("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
